// File: rtl/conv1d_sequencer.sv
// rtl/conv1d_sequencer.sv - loop-nest sequencer for the conv1d MAC datapath
//
// Walks (out_x, filter_x, ch) with ch innermost and issues one MAC operand
// pair per cycle. It produces buffer read addresses, padding-aware tap flags,
// MAC clear/enable/last strobes and output-buffer write strobes.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, abort          run control from the command decoder
//   cfg_width, cfg_depth  W positions, D input channels (latched at start)
//   busy, done, err       run status; err pulses with done on illegal config
//   in_rd_en, in_addr     input buffer read (valid taps only)
//   k_rd_en, k_addr       kernel buffer read (every issue)
//   mac_en, tap_valid     MAC operand strobe, RD_LAT after issue
//   mac_clear, acc_last   first/last MAC of each output position
//   out_wr_en, out_addr   output buffer write, one cycle after acc_last
module conv1d_sequencer #(
    parameter int MAX_WIDTH = 1024,
    parameter int MAX_CH    = 128,
    parameter int KLEN      = 8,
    parameter int PAD_LEFT  = 3,
    parameter int RD_LAT    = 1,
    parameter int IN_AW     = 17,
    parameter int K_AW      = 10,
    parameter int OUT_AW    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       cfg_width,
    input  logic [7:0]        cfg_depth,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              in_rd_en,
    output logic [IN_AW-1:0]  in_addr,
    output logic              k_rd_en,
    output logic [K_AW-1:0]   k_addr,
    output logic              mac_en,
    output logic              tap_valid,
    output logic              mac_clear,
    output logic              acc_last,
    output logic              out_wr_en,
    output logic [OUT_AW-1:0] out_addr
);

    localparam int FXW = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam int PW  = 18;   // signed tap position p
    localparam int DCW = 2;    // drain counter, RD_LAT <= 3

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [15:0]                w_q, w_d;
    logic [7:0]                 d_q, d_d;
    logic                       err_q, err_d;
    logic [OUT_AW:0]            out_x_q, out_x_d;
    logic [FXW-1:0]             fx_q, fx_d;
    logic [7:0]                 ch_q, ch_d;
    logic signed [PW-1:0]       p_q, p_d;
    logic [IN_AW-1:0]           in_cur_q, in_cur_d;
    logic [IN_AW-1:0]           row_base_q, row_base_d;
    logic [K_AW-1:0]            k_cur_q, k_cur_d;
    logic [DCW-1:0]             drain_q, drain_d;
    logic [RD_LAT-1:0]          pl_en_q, pl_en_d;
    logic [RD_LAT-1:0]          pl_tv_q, pl_tv_d;
    logic [RD_LAT-1:0]          pl_clr_q, pl_clr_d;
    logic [RD_LAT-1:0]          pl_last_q, pl_last_d;
    logic [RD_LAT-1:0][OUT_AW-1:0] pl_x_q, pl_x_d;
    logic                       out_wr_q, out_wr_d;
    logic [OUT_AW-1:0]          out_addr_q, out_addr_d;

    logic             issue;
    logic             tv;
    logic             ch_last;
    logic             fx_last;
    logic             x_last;
    logic             row_end;
    logic             cfg_legal;
    logic [IN_AW-1:0] next_row_base;

    assign issue   = (state_q == S_RUN);
    assign tv      = issue && !p_q[PW-1] && (p_q[PW-2:0] < {1'b0, w_q});
    assign ch_last = (ch_q == d_q - 8'd1);
    assign fx_last = (fx_q == FXW'(KLEN - 1));
    assign x_last  = (({{(15-OUT_AW){1'b0}}, out_x_q} + 16'd1) == w_q);
    assign row_end = fx_last && ch_last;

    assign cfg_legal = (cfg_width != 16'd0) && (cfg_width <= 16'(MAX_WIDTH)) &&
                       (cfg_depth != 8'd0) && (cfg_depth <= 8'(MAX_CH));

    // The input address only advances on valid taps, so each row starts at
    // max(0, out_x - PAD_LEFT) * D. Once rows begin past the left padding that
    // start point moves by exactly D per row.
    assign next_row_base = (out_x_q >= (OUT_AW+1)'(PAD_LEFT))
                         ? row_base_q + {{(IN_AW-8){1'b0}}, d_q}
                         : row_base_q;

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_DONE) && err_q;
    assign in_rd_en  = tv;
    assign in_addr   = tv ? in_cur_q : '0;
    assign k_rd_en   = issue;
    assign k_addr    = issue ? k_cur_q : '0;
    assign mac_en    = pl_en_q[RD_LAT-1];
    assign tap_valid = pl_tv_q[RD_LAT-1];
    assign mac_clear = pl_clr_q[RD_LAT-1];
    assign acc_last  = pl_last_q[RD_LAT-1];
    assign out_wr_en = out_wr_q;
    assign out_addr  = out_addr_q;

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        d_d        = d_q;
        err_d      = err_q;
        out_x_d    = out_x_q;
        fx_d       = fx_q;
        ch_d       = ch_q;
        p_d        = p_q;
        in_cur_d   = in_cur_q;
        row_base_d = row_base_q;
        k_cur_d    = k_cur_q;
        drain_d    = drain_q;

        // Issue-stage flags shift down the read-latency pipeline.
        pl_en_d[0]   = issue;
        pl_tv_d[0]   = tv;
        pl_clr_d[0]  = issue && (fx_q == '0) && (ch_q == 8'd0);
        pl_last_d[0] = issue && row_end;
        pl_x_d[0]    = out_x_q[OUT_AW-1:0];
        for (int i = 1; i < RD_LAT; i++) begin
            pl_en_d[i]   = pl_en_q[i-1];
            pl_tv_d[i]   = pl_tv_q[i-1];
            pl_clr_d[i]  = pl_clr_q[i-1];
            pl_last_d[i] = pl_last_q[i-1];
            pl_x_d[i]    = pl_x_q[i-1];
        end
        out_wr_d   = pl_en_q[RD_LAT-1] && pl_last_q[RD_LAT-1];
        out_addr_d = out_wr_d ? pl_x_q[RD_LAT-1] : '0;

        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (start && !abort) begin
                    w_d        = cfg_width;
                    d_d        = cfg_depth;
                    out_x_d    = '0;
                    fx_d       = '0;
                    ch_d       = '0;
                    p_d        = '0 - PW'(PAD_LEFT);
                    in_cur_d   = '0;
                    row_base_d = '0;
                    k_cur_d    = '0;
                    if (cfg_legal) begin
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (row_end) begin
                    if (x_last) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        out_x_d    = out_x_q + (OUT_AW+1)'(1);
                        fx_d       = '0;
                        ch_d       = '0;
                        // From p = x-PAD+KLEN-1 back to (x+1)-PAD.
                        p_d        = p_q + PW'(2) - PW'(KLEN);
                        k_cur_d    = '0;
                        in_cur_d   = next_row_base;
                        row_base_d = next_row_base;
                    end
                end else begin
                    k_cur_d  = k_cur_q + K_AW'(1);
                    in_cur_d = in_cur_q + IN_AW'(tv);
                    if (ch_last) begin
                        ch_d = '0;
                        fx_d = fx_q + FXW'(1);
                        p_d  = p_q + PW'(1);
                    end else begin
                        ch_d = ch_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (drain_q == DCW'(RD_LAT)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort kills everything in flight so no late MAC or write escapes.
        if (abort && ((state_q == S_RUN) || (state_q == S_DRAIN))) begin
            pl_en_d    = '0;
            pl_tv_d    = '0;
            pl_clr_d   = '0;
            pl_last_d  = '0;
            pl_x_d     = '0;
            out_wr_d   = 1'b0;
            out_addr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            d_q        <= '0;
            err_q      <= 1'b0;
            out_x_q    <= '0;
            fx_q       <= '0;
            ch_q       <= '0;
            p_q        <= '0;
            in_cur_q   <= '0;
            row_base_q <= '0;
            k_cur_q    <= '0;
            drain_q    <= '0;
            pl_en_q    <= '0;
            pl_tv_q    <= '0;
            pl_clr_q   <= '0;
            pl_last_q  <= '0;
            pl_x_q     <= '0;
            out_wr_q   <= 1'b0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            d_q        <= d_d;
            err_q      <= err_d;
            out_x_q    <= out_x_d;
            fx_q       <= fx_d;
            ch_q       <= ch_d;
            p_q        <= p_d;
            in_cur_q   <= in_cur_d;
            row_base_q <= row_base_d;
            k_cur_q    <= k_cur_d;
            drain_q    <= drain_d;
            pl_en_q    <= pl_en_d;
            pl_tv_q    <= pl_tv_d;
            pl_clr_q   <= pl_clr_d;
            pl_last_q  <= pl_last_d;
            pl_x_q     <= pl_x_d;
            out_wr_q   <= out_wr_d;
            out_addr_q <= out_addr_d;
        end
    end

endmodule

// File: tb/tb_conv1d_sequencer.sv
// tb/tb_conv1d_sequencer.sv - scoreboard bench for conv1d_sequencer
module tb_conv1d_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] cfg_width;
    logic [7:0]  cfg_depth;
    logic        busy;
    logic        done;
    logic        err;
    logic        in_rd_en;
    logic [16:0] in_addr;
    logic        k_rd_en;
    logic [9:0]  k_addr;
    logic        mac_en;
    logic        tap_valid;
    logic        mac_clear;
    logic        acc_last;
    logic        out_wr_en;
    logic [9:0]  out_addr;

    conv1d_sequencer #(
        .MAX_WIDTH(1024), .MAX_CH(128), .KLEN(8), .PAD_LEFT(3),
        .RD_LAT(1), .IN_AW(17), .K_AW(10), .OUT_AW(10)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_width(cfg_width), .cfg_depth(cfg_depth),
        .busy(busy), .done(done), .err(err),
        .in_rd_en(in_rd_en), .in_addr(in_addr),
        .k_rd_en(k_rd_en), .k_addr(k_addr),
        .mac_en(mac_en), .tap_valid(tap_valid),
        .mac_clear(mac_clear), .acc_last(acc_last),
        .out_wr_en(out_wr_en), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; logic rd; logic [16:0] ia; logic [9:0] ka;} iss_t;
    typedef struct {int cyc; logic tv; logic clr; logic last;} mac_t;
    typedef struct {int cyc; logic [9:0] addr;} wr_t;
    typedef struct {int cyc; logic err;} done_t;

    iss_t  iss_q[$];
    mac_t  mac_q[$];
    wr_t   wr_q[$];
    done_t done_q[$];

    int cyc     = 0;
    int tests   = 0;
    int fails   = 0;
    int busy_lo = 1;
    int busy_hi = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, err, in_rd_en, in_addr, k_rd_en, k_addr, mac_en,
                    tap_valid, mac_clear, acc_last, out_wr_en, out_addr});
    endfunction

    task automatic check_cycle();
        iss_t  ie;
        mac_t  me;
        wr_t   we;
        done_t de;
        if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
            ie = iss_q.pop_front();
            chk("k_rd_en", 64'(k_rd_en), 64'(1));
            chk("in_rd_en", 64'(in_rd_en), 64'(ie.rd));
            chk("in_addr", 64'(in_addr), 64'(ie.ia));
            chk("k_addr", 64'(k_addr), 64'(ie.ka));
        end else begin
            chk("k_rd_en idle", 64'(k_rd_en), 64'(0));
            chk("in_rd_en idle", 64'(in_rd_en), 64'(0));
        end
        if (mac_q.size() > 0 && mac_q[0].cyc == cyc) begin
            me = mac_q.pop_front();
            chk("mac_en", 64'(mac_en), 64'(1));
            chk("tap_valid", 64'(tap_valid), 64'(me.tv));
            chk("mac_clear", 64'(mac_clear), 64'(me.clr));
            chk("acc_last", 64'(acc_last), 64'(me.last));
        end else begin
            chk("mac idle", 64'({mac_en, tap_valid, mac_clear, acc_last}), 64'(0));
        end
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
            we = wr_q.pop_front();
            chk("out_wr_en", 64'(out_wr_en), 64'(1));
            chk("out_addr", 64'(out_addr), 64'(we.addr));
        end else begin
            chk("out_wr_en idle", 64'(out_wr_en), 64'(0));
        end
        if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
            de = done_q.pop_front();
            chk("done", 64'(done), 64'(1));
            chk("err", 64'(err), 64'(de.err));
        end else begin
            chk("done idle", 64'({done, err}), 64'(0));
        end
        chk("busy", 64'(busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic clear_expect();
        iss_q.delete();
        mac_q.delete();
        wr_q.delete();
        done_q.delete();
        busy_lo = 1;
        busy_hi = 0;
    endtask

    // Drops everything the model predicted after cycle a (abort taken there).
    task automatic purge_after(input int a);
        while (iss_q.size() > 0 && iss_q[$].cyc > a) void'(iss_q.pop_back());
        while (mac_q.size() > 0 && mac_q[$].cyc > a) void'(mac_q.pop_back());
        while (wr_q.size() > 0 && wr_q[$].cyc > a) void'(wr_q.pop_back());
        while (done_q.size() > 0 && done_q[$].cyc > a) void'(done_q.pop_back());
        if (busy_hi > a) busy_hi = a;
    endtask

    // Drive start in the current cycle and push the reference schedule.
    task automatic launch(input int w, input int d);
        int  s;
        int  n;
        int  p;
        logic v;
        s = cyc;
        cfg_width = 16'(w);
        cfg_depth = 8'(d);
        start = 1'b1;
        if (w < 1 || w > 1024 || d < 1 || d > 128) begin
            done_q.push_back('{s + 1, 1'b1});
        end else begin
            n = 0;
            for (int x = 0; x < w; x++) begin
                for (int fx = 0; fx < 8; fx++) begin
                    for (int ch = 0; ch < d; ch++) begin
                        p = x - 3 + fx;
                        v = (p >= 0) && (p < w);
                        iss_q.push_back('{s + 1 + n, v, v ? 17'(p * d + ch) : 17'd0, 10'(fx * d + ch)});
                        mac_q.push_back('{s + 2 + n, v, (fx == 0 && ch == 0), (fx == 7 && ch == d - 1)});
                        if (fx == 7 && ch == d - 1) wr_q.push_back('{s + 3 + n, 10'(x)});
                        n++;
                    end
                end
            end
            done_q.push_back('{s + n + 3, 1'b0});
            busy_lo = s + 1;
            busy_hi = s + n + 2;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_ignored_start();
        start = 1'b1;
        cfg_width = 16'd3;
        cfg_depth = 8'd2;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int s;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_width = 16'd0;
        cfg_depth = 8'd0;
        #3;
        chk("reset outputs", all_outs(), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) tick();

        // W=2, D=1: padding on both sides of a short row.
        launch(2, 1);
        repeat (21) tick();

        // W=1, D=3: kernel address walks 0..23.
        launch(1, 3);
        repeat (28) tick();

        // Illegal configs.
        launch(1, 0);
        repeat (3) tick();
        launch(1025, 1);
        repeat (3) tick();
        launch(0, 4);
        repeat (3) tick();

        // W=4, D=2 aborted in cycle s+20, then a full rerun.
        s = cyc;
        launch(4, 2);
        while (cyc < s + 20) tick();
        abort = 1'b1;
        purge_after(cyc);
        tick();
        abort = 1'b0;
        tick();
        launch(4, 2);
        repeat (70) tick();

        // Starts during RUN and in the DONE cycle are ignored.
        s = cyc;
        launch(1, 1);
        while (cyc < s + 5) tick();
        pulse_ignored_start();
        while (cyc < s + 11) tick();
        chk("done cycle reached", 64'(done), 64'(1));
        pulse_ignored_start();
        repeat (14) tick();

        // Asynchronous reset between edges in the middle of a run.
        launch(4, 2);
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async reset outputs", all_outs(), 64'(0));
        clear_expect();
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        launch(2, 1);
        repeat (21) tick();

        chk("scoreboard drained", 64'(iss_q.size() + mac_q.size() + wr_q.size() + done_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv1d_sequencer.md
Name: conv1d_sequencer

Overview:
- Multi-cycle controller that walks the 1-D convolution loop nest (output position, filter tap, input channel) for the CFU conv1d datapath.
- Generates read addresses for the input and kernel buffers, padding-aware tap-valid flags, MAC clear/enable/last strobes, and output-buffer write strobes.
- Replaces the single-cycle nested-loop compute command with a one-MAC-per-cycle schedule. It sits between the CFU command decoder (start/abort/config) and the buffer RAMs plus MAC unit.

Parameters:
MAX_WIDTH, 1024, maximum input/output width (positions)
MAX_CH, 128, maximum input channels
KLEN, 8, filter taps
PAD_LEFT, 3, left padding (p = out_x - PAD_LEFT + filter_x)
RD_LAT, 1, buffer RAM read latency in cycles (1..3)
IN_AW, 17, input buffer address width
K_AW, 10, kernel buffer address width
OUT_AW, 10, output buffer address width

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  cancel the run in progress
cfg_width  in  16  W, valid range 1..MAX_WIDTH
cfg_depth  in  8  D, valid range 1..MAX_CH
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done when the config is illegal
in_rd_en  out  1  input buffer read strobe (valid taps only)
in_addr  out  IN_AW  p*D + ch; 0 when tap invalid
k_rd_en  out  1  kernel buffer read strobe
k_addr  out  K_AW  filter_x*D + ch
mac_en  out  1  MAC operand valid (RD_LAT after issue)
tap_valid  out  1  with mac_en; 0 = padding, MAC must add 0
mac_clear  out  1  with first mac_en of each output
acc_last  out  1  with last mac_en of each output
out_wr_en  out  1  write accumulator to output buffer
out_addr  out  OUT_AW  out_x of the write

Behaviour:
- Reset (async, any state): state=IDLE; every output 0; counters and pipeline cleared. A run interrupted by reset leaves no further strobes.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches cfg_width/cfg_depth (config is ignored afterwards).
  - Legal config -> RUN.
  - W=0, W>MAX_WIDTH, D=0 or D>MAX_CH -> DONE with err=1; no strobes; busy stays 0.
- RUN issues one (out_x, filter_x, ch) triple per cycle.
  - Loop order: ch innermost, then filter_x, then out_x.
  - N = W*KLEN*D issue cycles; first issue is the cycle after the start edge.
  - k_rd_en=1 every issue cycle.
  - Tap is valid iff 0 <= p < W. in_rd_en=tap valid.
  - Addresses are produced by incremental adders only; no multipliers.
  - After the final issue -> DRAIN.
- Pipeline timing:
  - mac_en, tap_valid, mac_clear, acc_last are the issue-stage flags delayed exactly RD_LAT cycles.
  - out_wr_en and out_addr follow acc_last by 1 cycle.
- DRAIN lasts RD_LAT+1 cycles and ends after the last out_wr_en. Then DONE.
- DONE: done=1 for one cycle, busy=0; next state IDLE.
- busy=1 in RUN and DRAIN only.
- Timing with start sampled at edge 0:
  - issues on cycles 1..N
  - output x written at cycle (x+1)*KLEN*D + RD_LAT + 1
  - done at cycle N + RD_LAT + 2
- start outside IDLE (including the DONE cycle) is ignored.
- abort in RUN or DRAIN:
  - next cycle state=IDLE and all strobes 0, including in-flight pipeline stages. No further out_wr_en, no done.
  - abort in IDLE or DONE has no effect.
  - abort wins over start in the same cycle.
- Counters: out_x is OUT_AW+1 bits; in_addr is computed at full width, then truncated. No wrap occurs for legal configs (max address MAX_WIDTH*MAX_CH-1).

Test Plan:
1. W=2, D=1, RD_LAT=1, start at edge 0 -> 16 issues on cycles 1..16.
   - in_rd_en on filter_x 3,4 for out0 (in_addr 0,1) and filter_x 2,3 for out1 (in_addr 0,1).
   - out_wr_en addr0 @10, addr1 @18; done @19; busy high cycles 1..18.
2. W=1, D=3 -> k_addr runs 0..23 sequentially; tap (filter_x=2, ch=1) gives k_addr=7.
   - Valid taps only at filter_x=3 with in_addr 0,1,2.
   - mac_clear on cycle 2, acc_last on cycle 25, out_wr_en addr0 @26, done @27.
3. cfg_depth=0 or cfg_width=1025 -> done=err=1 @1 only; busy, in_rd_en, mac_en, out_wr_en never asserted.
4. W=4, D=2, abort at cycle 20 -> from cycle 21 all strobes 0; only out_wr addr0 (@18) occurred; no done; new start at cycle 22 runs a full sequence.
5. start pulsed at cycles 5 and 2+N+RD_LAT (the DONE cycle) during a run -> both ignored; single done.
6. reset asserted asynchronously mid-RUN (between edges) -> all outputs 0 immediately; state IDLE after release; next start behaves as in scenario 1.
